csi_lane_sequencer: RTL and testbench
=====================================

Name: csi_lane_sequencer

Overview:
- Protocol-side controller for the single-lane HS-only D-PHY receiver.
- Consumes the receiver's byte stream (rx_data/rx_enable) and frames CSI-2 packets: 4-byte header, then payload and 2-byte CRC for long packets.
- Drives the receiver's synchronous reset (phy_reset) after the last byte of every packet, on timeout, and on bad word count, so the receiver re-hunts for the next sync sequence.
- Sits between the D-PHY receiver and the CSI-2 pixel unpacker, in the clock_p domain.

Parameters:
- TIMEOUT_CYCLES, 64: clock_p cycles without rx_enable, mid-packet, before abort; >=8.
- MAX_WORD_COUNT, 4096: largest legal long-packet WC; larger aborts the packet.
- RESET_CYCLES, 2: cycles phy_reset is held per assertion; >=1.

Ports:
- clock_p  input  1  D-PHY HS clock (rising edge used)
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  byte from D-PHY receiver, valid when rx_enable=1
- rx_enable  input  1  receiver byte strobe (at most one per 4 cycles)
- phy_reset  output  1  synchronous reset to receiver
- header_valid  output  1  1-cycle pulse: header fields below updated
- virtual_channel  output  2  DI[7:6]
- data_type  output  6  DI[5:0]
- word_count  output  16  {byte2, byte1}
- ecc  output  8  header byte 3, raw, unchecked
- payload_data  output  8  payload byte
- payload_valid  output  1  payload_data qualifier
- crc  output  16  {crc_hi, crc_lo}, raw, unchecked; valid with packet_end on long packets
- packet_end  output  1  1-cycle pulse: packet complete
- error  output  1  1-cycle pulse: timeout or WC > MAX_WORD_COUNT

Behaviour:
- Async reset:
  - state=FLUSH, flush counter=RESET_CYCLES-1.
  - phy_reset=1.
  - All pulses and strobes 0; header/crc/payload registers 0.
- All outputs are registered. Each output strobe fires in the cycle after the rx_enable that carries the triggering byte.
- States:
  - IDLE: first rx_enable byte -> latch DI, byte index=1 -> HEADER.
  - HEADER: bytes 1..3 latch WC lo, WC hi, ECC. On ECC byte:
    - header_valid=1.
    - DT<0x10 (short): packet_end=1 in the same cycle -> FLUSH.
    - Else WC>MAX_WORD_COUNT: error=1 -> FLUSH; no packet_end.
    - Else WC=0 -> CRC.
    - Else load remaining=WC -> PAYLOAD.
  - PAYLOAD: each rx_enable -> payload_valid=1, payload_data=rx_data, remaining-1. The byte that takes remaining to 0 goes -> CRC.
  - CRC: two bytes latched lo, hi; on the second, packet_end=1 -> FLUSH.
  - FLUSH: phy_reset=1 for RESET_CYCLES cycles, then -> IDLE, phy_reset=0.
- rx_enable in FLUSH is ignored; no output is produced.
- Timeout:
  - In HEADER/PAYLOAD/CRC, an idle counter increments each cycle without rx_enable and clears on rx_enable.
  - At TIMEOUT_CYCLES: error=1 -> FLUSH; no packet_end.
  - The counter does not run in IDLE or FLUSH.
- Widths: remaining is a 16-bit down-counter that never wraps. WC=0xFFFF with a large MAX is legal.
- phy_reset and FLUSH entry are registered from the terminating byte's cycle. phy_reset rises exactly 1 cycle after the last byte's rx_enable.
- Reset mid-packet discards everything: no packet_end, no error.

Decomposition:
- Package mipi_csi_2_pkg:
  - State enum (IDLE, HEADER, PAYLOAD, CRC, FLUSH).
  - SHORT_PACKET_DT_MAX = 6'h0F.
  - Header field slicing constants.
- Sub-module csi_idle_timer: idle counter with clear/enable and a terminal-count flag, parameterised by TIMEOUT_CYCLES. Everything else is in one FSM.

Test Plan:
- Short packet, rx_enable every 4 cycles with bytes 00,00,00,ECC (frame start, VC0):
  - header_valid with dt=0x00, wc=0.
  - packet_end in the same cycle.
  - phy_reset high for 2 cycles starting 1 cycle after the ECC byte; no payload_valid.
- Long packet DI=0x2A, WC=4, payload 11,22,33,44, CRC BE,EF:
  - 4 payload_valid pulses in order.
  - packet_end with crc=0xEFBE.
  - phy_reset follows.
- Long packet DT=0x2A, WC=0: next two bytes are CRC, then packet_end; no payload_valid.
- Stop rx_enable after 2 payload bytes of a WC=8 packet:
  - error exactly 64 cycles after the last enable; no packet_end.
  - phy_reset asserted, then IDLE.
  - A new packet is then accepted.
- Header with WC=0x2000 (>4096): header_valid and error in the same cycle; FLUSH; no payload_valid.
- Assert reset mid-payload:
  - Outputs go to reset values immediately.
  - phy_reset=1 for 2 cycles after release.
  - The next packet frames correctly.

Source files
------------

// File: rtl/mipi_csi_2_pkg.sv
// Shared types and header-field constants for the CSI-2 lane sequencer.
// The state enum, header layout and short/long packet split live here.
package mipi_csi_2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CRC,
    ST_FLUSH
  } seq_state_e;

  localparam logic [5:0] SHORT_PACKET_DT_MAX = 6'h0F;

  // DI byte layout: {VC[1:0], DT[5:0]}
  localparam int DI_VC_LSB = 6;
  localparam int DI_DT_LSB = 0;

  // Header byte positions after DI (byte 0)
  localparam logic [1:0] HDR_IDX_WC_LO = 2'd1;
  localparam logic [1:0] HDR_IDX_WC_HI = 2'd2;
  localparam logic [1:0] HDR_IDX_ECC   = 2'd3;

  typedef struct packed {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  ecc;
  } csi_header_t;

  function automatic logic is_short_dt(input logic [5:0] dt);
    return dt <= SHORT_PACKET_DT_MAX;
  endfunction

endpackage

// File: rtl/csi_idle_timer.sv
// Counts clock_p cycles since the last received byte while a packet is open.
// expired flags the cycle in which the TIMEOUT_CYCLES-th idle edge lands.
module csi_idle_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock_p,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Loading 1 on a byte makes count equal the cycles elapsed since that byte,
  // so the registered error lands exactly TIMEOUT_CYCLES after the strobe.
  always_ff @(posedge clock_p or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= CW'(1);
    else if (!enable)
      count <= '0;
    else if (count != TERMINAL)
      count <= count + 1'b1;
  end

  assign expired = enable && !clear && (count == TERMINAL);

endmodule

// File: rtl/csi_lane_sequencer.sv
// Frames CSI-2 packets from a single-lane D-PHY byte stream and resets the
// receiver after each packet, on idle timeout, or on an oversized word count.
import mipi_csi_2_pkg::*;

module csi_lane_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_WORD_COUNT = 4096,
  parameter int RESET_CYCLES   = 2
) (
  input  logic        clock_p,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_enable,
  output logic        phy_reset,
  output logic        header_valid,
  output logic [1:0]  virtual_channel,
  output logic [5:0]  data_type,
  output logic [15:0] word_count,
  output logic [7:0]  ecc,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic [15:0] crc,
  output logic        packet_end,
  output logic        error
);
  localparam int FCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(RESET_CYCLES - 1);
  localparam logic [31:0] MAX_WC = 32'(MAX_WORD_COUNT);

  seq_state_e     state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [FCW-1:0] flush_q, flush_d;
  logic [15:0]    rem_q, rem_d;
  logic [1:0]     vc_q, vc_d;
  logic [5:0]     dt_q, dt_d;
  logic [15:0]    wc_q, wc_d;
  logic [7:0]     crc_lo_q, crc_lo_d;
  csi_header_t    hdr_q, hdr_d;
  logic [15:0]    crc_d;
  logic [7:0]     payload_data_d;
  logic           phy_reset_d, header_valid_d, payload_valid_d, packet_end_d, error_d;
  logic           go_flush, timed, idle_expired;

  assign timed = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD) || (state_q == ST_CRC);

  csi_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock_p (clock_p),
    .reset   (reset),
    .clear   (rx_enable && (state_q != ST_FLUSH)),
    .enable  (timed),
    .expired (idle_expired)
  );

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    flush_d         = flush_q;
    rem_d           = rem_q;
    vc_d            = vc_q;
    dt_d            = dt_q;
    wc_d            = wc_q;
    crc_lo_d        = crc_lo_q;
    hdr_d           = hdr_q;
    crc_d           = crc;
    payload_data_d  = payload_data;
    phy_reset_d     = phy_reset;
    header_valid_d  = 1'b0;
    payload_valid_d = 1'b0;
    packet_end_d    = 1'b0;
    error_d         = 1'b0;
    go_flush        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_enable) begin
          vc_d    = rx_data[DI_VC_LSB +: 2];
          dt_d    = rx_data[DI_DT_LSB +: 6];
          idx_d   = HDR_IDX_WC_LO;
          state_d = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (rx_enable) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            HDR_IDX_WC_LO: wc_d[7:0]  = rx_data;
            HDR_IDX_WC_HI: wc_d[15:8] = rx_data;
            HDR_IDX_ECC: begin
              hdr_d          = '{vc: vc_q, dt: dt_q, wc: wc_q, ecc: rx_data};
              header_valid_d = 1'b1;
              idx_d          = 2'd0;
              if (is_short_dt(dt_q)) begin
                packet_end_d = 1'b1;
                go_flush     = 1'b1;
              end else if ({16'd0, wc_q} > MAX_WC) begin
                error_d  = 1'b1;
                go_flush = 1'b1;
              end else if (wc_q == 16'd0) begin
                state_d = ST_CRC;
              end else begin
                rem_d   = wc_q;
                state_d = ST_PAYLOAD;
              end
            end
            default: ;
          endcase
        end else if (idle_expired) begin
          error_d  = 1'b1;
          go_flush = 1'b1;
        end
      end

      ST_PAYLOAD: begin
        if (rx_enable) begin
          payload_valid_d = 1'b1;
          payload_data_d  = rx_data;
          rem_d           = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            idx_d   = 2'd0;
            state_d = ST_CRC;
          end
        end else if (idle_expired) begin
          error_d  = 1'b1;
          go_flush = 1'b1;
        end
      end

      ST_CRC: begin
        if (rx_enable) begin
          if (idx_q == 2'd0) begin
            crc_lo_d = rx_data;
            idx_d    = 2'd1;
          end else begin
            crc_d        = {rx_data, crc_lo_q};
            packet_end_d = 1'b1;
            go_flush     = 1'b1;
          end
        end else if (idle_expired) begin
          error_d  = 1'b1;
          go_flush = 1'b1;
        end
      end

      ST_FLUSH: begin
        // Bytes arriving here belong to nothing; the receiver is being reset.
        if (flush_q == '0) begin
          phy_reset_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end

      default: go_flush = 1'b1;
    endcase

    if (go_flush) begin
      state_d     = ST_FLUSH;
      flush_d     = FLUSH_LOAD;
      phy_reset_d = 1'b1;
    end
  end

  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FLUSH;
      flush_q       <= FLUSH_LOAD;
      idx_q         <= '0;
      rem_q         <= '0;
      vc_q          <= '0;
      dt_q          <= '0;
      wc_q          <= '0;
      crc_lo_q      <= '0;
      hdr_q         <= '0;
      crc           <= '0;
      payload_data  <= '0;
      phy_reset     <= 1'b1;
      header_valid  <= 1'b0;
      payload_valid <= 1'b0;
      packet_end    <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      idx_q         <= idx_d;
      rem_q         <= rem_d;
      vc_q          <= vc_d;
      dt_q          <= dt_d;
      wc_q          <= wc_d;
      crc_lo_q      <= crc_lo_d;
      hdr_q         <= hdr_d;
      crc           <= crc_d;
      payload_data  <= payload_data_d;
      phy_reset     <= phy_reset_d;
      header_valid  <= header_valid_d;
      payload_valid <= payload_valid_d;
      packet_end    <= packet_end_d;
      error         <= error_d;
    end
  end

  assign virtual_channel = hdr_q.vc;
  assign data_type       = hdr_q.dt;
  assign word_count      = hdr_q.wc;
  assign ecc             = hdr_q.ecc;

endmodule

// File: tb/tb_csi_lane_sequencer.sv
// Directed and random CSI-2 packets against a packet-level reference model.
// A negedge monitor logs every DUT event with its cycle number.
module tb_csi_lane_sequencer;
  localparam int TMO   = 64;
  localparam int MAXWC = 4096;
  localparam int RST   = 2;

  logic        clock_p = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_enable = 1'b0;
  logic        phy_reset, header_valid, payload_valid, packet_end, error;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count, crc;
  logic [7:0]  ecc, payload_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  csi_lane_sequencer #(
    .TIMEOUT_CYCLES(TMO), .MAX_WORD_COUNT(MAXWC), .RESET_CYCLES(RST)
  ) dut (
    .clock_p(clock_p), .reset(reset), .rx_data(rx_data), .rx_enable(rx_enable),
    .phy_reset(phy_reset), .header_valid(header_valid),
    .virtual_channel(virtual_channel), .data_type(data_type),
    .word_count(word_count), .ecc(ecc), .payload_data(payload_data),
    .payload_valid(payload_valid), .crc(crc), .packet_end(packet_end), .error(error)
  );

  always #5 clock_p = ~clock_p;
  always @(posedge clock_p) cyc <= cyc + 1;

  // Event log, written only by the monitor.
  int          hv_c[$];
  logic [31:0] hv_f[$];
  int          pe_c[$];
  logic [15:0] pe_crc[$];
  int          err_c[$];
  logic [7:0]  pay_q[$];
  int          rise_q[$];
  int          len_q[$];
  logic        prev_pr = 1'b1;
  int          pr_len = 0;

  always @(negedge clock_p) begin
    if (header_valid) begin
      hv_c.push_back(cyc);
      hv_f.push_back({virtual_channel, data_type, word_count, ecc});
    end
    if (payload_valid) pay_q.push_back(payload_data);
    if (packet_end) begin
      pe_c.push_back(cyc);
      pe_crc.push_back(crc);
    end
    if (error) err_c.push_back(cyc);
    if (phy_reset) begin
      if (!prev_pr) begin
        rise_q.push_back(cyc);
        pr_len = 0;
      end
      pr_len++;
    end else if (prev_pr) begin
      len_q.push_back(pr_len);
    end
    prev_pr = phy_reset;
  end

  int b_hv, b_pe, b_err, b_pay, b_rise, b_len;
  int last_en;
  logic [7:0] pl_in[$];

  task automatic mark();
    b_hv = hv_c.size(); b_pe = pe_c.size(); b_err = err_c.size();
    b_pay = pay_q.size(); b_rise = rise_q.size(); b_len = len_q.size();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; last_en is the cycle in which this byte's outputs appear.
  task automatic send(input logic [7:0] b, input int gap);
    rx_data   = b;
    rx_enable = 1'b1;
    @(negedge clock_p);
    rx_enable = 1'b0;
    rx_data   = 8'($urandom);
    last_en   = cyc;
    repeat (gap - 1) @(negedge clock_p);
  endtask

  task automatic count_phy_high(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!phy_reset) break;
      n++;
      @(negedge clock_p);
    end
  endtask

  // Reference: short DT -> header+end; long with WC>MAX -> header+error;
  // otherwise header, WC payload bytes, then CRC with end on its high byte.
  task automatic run_packet(input logic [7:0] di, input logic [15:0] wc,
                            input logic [7:0] eb, input logic [15:0] cv, input int gap);
    bit shrt = (di[5:0] <= 6'h0F);
    bit over = !shrt && (int'(wc) > MAXWC);
    int npay = (shrt || over) ? 0 : int'(wc);
    int ecc_at;
    mark();
    while (pl_in.size() < npay) pl_in.push_back(8'($urandom));
    send(di, gap); send(wc[7:0], gap); send(wc[15:8], gap); send(eb, gap);
    ecc_at = last_en;
    if (!shrt && !over) begin
      for (int i = 0; i < npay; i++) send(pl_in[i], gap);
      send(cv[7:0], gap);
      send(cv[15:8], gap);
    end
    repeat (10) @(negedge clock_p);
    chk("hv_count", hv_c.size() - b_hv, 1);
    if (hv_c.size() > b_hv) begin
      chk("hv_fields", hv_f[b_hv], {di, wc, eb});
      chk("hv_cycle", hv_c[b_hv], ecc_at);
    end
    chk("payload_count", pay_q.size() - b_pay, npay);
    for (int i = 0; i < npay; i++)
      if (b_pay + i < pay_q.size()) chk("payload_byte", pay_q[b_pay + i], pl_in[i]);
    chk("end_count", pe_c.size() - b_pe, over ? 0 : 1);
    if (!over && pe_c.size() > b_pe) begin
      chk("end_cycle", pe_c[b_pe], last_en);
      if (!shrt) chk("end_crc", pe_crc[b_pe], cv);
    end
    chk("err_count", err_c.size() - b_err, over ? 1 : 0);
    if (over && err_c.size() > b_err) chk("err_cycle", err_c[b_err], ecc_at);
    chk("phy_rise_count", rise_q.size() - b_rise, 1);
    if (rise_q.size() > b_rise) chk("phy_rise_cycle", rise_q[b_rise], last_en);
    chk("phy_len_count", len_q.size() - b_len, 1);
    if (len_q.size() > b_len) chk("phy_len", len_q[b_len], RST);
    pl_in.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0]  di;
    logic [15:0] wc;

    repeat (3) @(negedge clock_p);
    chk("rst_phy", phy_reset, 1);
    chk("rst_hv", header_valid, 0);
    chk("rst_pv", payload_valid, 0);
    chk("rst_pe", packet_end, 0);
    chk("rst_err", error, 0);
    chk("rst_hdr", {virtual_channel, data_type, word_count, ecc}, 0);
    chk("rst_crc", crc, 0);
    reset = 1'b0;
    count_phy_high(n);
    chk("rel_phy_len", n, RST);
    repeat (4) @(negedge clock_p);
    chk("idle_phy", phy_reset, 0);

    // Short frame-start packet, long packet, empty long packet
    run_packet(8'h00, 16'h0000, 8'h5A, 16'h0000, 4);
    pl_in = {8'h11, 8'h22, 8'h33, 8'h44};
    run_packet(8'h2A, 16'd4, 8'h3C, 16'hEFBE, 4);
    run_packet(8'h2A, 16'd0, 8'h12, 16'h1234, 5);

    // Idle timeout after 2 of 8 payload bytes
    mark();
    send(8'h2A, 4); send(8'h08, 4); send(8'h00, 4); send(8'h33, 4);
    send(8'hA1, 4); send(8'hA2, 4);
    for (int i = 0; i < 200 && err_c.size() == b_err; i++) @(negedge clock_p);
    chk("tmo_err_count", err_c.size() - b_err, 1);
    if (err_c.size() > b_err) begin
      chk("tmo_err_cycle", err_c[b_err], last_en + TMO - 1);
      if (rise_q.size() > b_rise) chk("tmo_phy_rise", rise_q[b_rise], err_c[b_err]);
    end
    chk("tmo_end_count", pe_c.size() - b_pe, 0);
    chk("tmo_payload_count", pay_q.size() - b_pay, 2);
    repeat (6) @(negedge clock_p);
    chk("tmo_phy_released", phy_reset, 0);
    run_packet(8'h6B, 16'd3, 8'h77, 16'hC0DE, 4);

    // Oversized word count
    run_packet(8'h2A, 16'h2000, 8'h11, 16'h0000, 4);

    // Reset mid-payload
    send(8'h2A, 4); send(8'h06, 4); send(8'h00, 4); send(8'h44, 4);
    send(8'h9C, 4); send(8'h9D, 4); send(8'h9E, 4);
    @(posedge clock_p);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_phy", phy_reset, 1);
    chk("mid_rst_wc", word_count, 0);
    chk("mid_rst_dt", data_type, 0);
    chk("mid_rst_pdata", payload_data, 0);
    chk("mid_rst_strobes", {header_valid, payload_valid, packet_end, error}, 0);
    mark();
    @(negedge clock_p);
    reset = 1'b0;
    count_phy_high(n);
    chk("mid_rst_phy_len", n, RST);
    repeat (8) @(negedge clock_p);
    chk("mid_rst_end_count", pe_c.size() - b_pe, 0);
    chk("mid_rst_err_count", err_c.size() - b_err, 0);
    chk("mid_rst_payload_count", pay_q.size() - b_pay, 0);
    run_packet(8'h2A, 16'd5, 8'h0F, 16'hBEEF, 4);

    // Random mix of short, long and oversized packets
    for (int k = 0; k < 10; k++) begin
      di = 8'($urandom);
      if ($urandom_range(0, 9) == 0) wc = 16'($urandom_range(MAXWC + 1, 65535));
      else                           wc = 16'($urandom_range(0, 10));
      run_packet(di, wc, 8'($urandom), 16'($urandom), int'($urandom_range(4, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
